// File: rtl/aes_wb_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_wb_loader
// Purpose  : Wishbone slave front end for the decrypt_aes128 core. Assembles
//            128-bit ciphertext and key registers from 32-bit bus writes,
//            sequences the core (one-cycle reset pulse, then a fixed-latency
//            run window), captures the plaintext into read-back registers and
//            pulses a completion interrupt.
// Ports    : clk, decReset_n      - clock, async active-low reset
//            wbs_*                - Wishbone slave (cyc/stb/we/sel/adr/dat, ack/dat)
//            core_in, core_key    - ciphertext / key to the core
//            core_rst             - active-high reset to the core
//            core_out             - plaintext from the core
//            irq                  - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module aes_wb_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEC_LATENCY = 12
) (
    input  logic         clk,
    input  logic         decReset_n,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [127:0] core_in,
    output logic [127:0] core_key,
    output logic         core_rst,
    input  logic [127:0] core_out,
    output logic         irq
);

    localparam int                 c_CNT_W    = $clog2(DEC_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEC_LATENCY - 1);
    localparam logic [5:0]         c_W_CTRL   = 6'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CRST = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [127:0]         r_cipher;
    logic [127:0]         r_key;
    logic [127:0]         r_result;
    logic                 r_done;
    logic                 r_start;
    logic                 r_ack;
    logic [31:0]          r_dat;

    logic                 w_busy;
    logic                 w_core_rst;
    logic                 w_irq;
    logic                 w_hit;
    logic                 w_acc;
    logic                 w_wr;
    logic                 w_start_wr;
    logic [5:0]           w_word;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    // Byte addresses are word aligned; the low two bits carry no information.
    assign w_unused = ^wbs_adr_i[1:0];

    function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  sel);
        logic [31:0] v;
        v = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) v[8*b +: 8] = new_w[8*b +: 8];
        end
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Bus decode. An access is accepted only while ack is low, which forces
    // every access to take at least two cycles and ack to be a single pulse.
    // ------------------------------------------------------------------------
    assign w_hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_acc      = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
    assign w_wr       = w_acc & wbs_we_i;
    assign w_word     = wbs_adr_i[7:2];
    // A start seen while busy (including the completion cycle) is dropped.
    assign w_start_wr = w_wr & (w_word == c_W_CTRL) & wbs_sel_i[0] & wbs_dat_i[0] & ~w_busy;

    always_comb begin
        w_rdata = '0;
        case (w_word)
            6'd0:    w_rdata = r_cipher[127:96];
            6'd1:    w_rdata = r_cipher[95:64];
            6'd2:    w_rdata = r_cipher[63:32];
            6'd3:    w_rdata = r_cipher[31:0];
            6'd4:    w_rdata = r_key[127:96];
            6'd5:    w_rdata = r_key[95:64];
            6'd6:    w_rdata = r_key[63:32];
            6'd7:    w_rdata = r_key[31:0];
            6'd8:    w_rdata = {30'b0, r_done, w_busy};
            6'd9:    w_rdata = r_result[127:96];
            6'd10:   w_rdata = r_result[95:64];
            6'd11:   w_rdata = r_result[63:32];
            6'd12:   w_rdata = r_result[31:0];
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge decReset_n) begin
        if (!decReset_n) begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_start <= 1'b0;
        end else begin
            r_ack   <= w_acc;
            r_dat   <= (w_acc && !wbs_we_i) ? w_rdata : 32'd0;
            r_start <= w_start_wr;
        end
    end

    // CIPHER / KEY words; writes while busy are acked but dropped so the core
    // inputs stay stable across a run.
    always_ff @(posedge clk or negedge decReset_n) begin
        if (!decReset_n) begin
            r_cipher <= '0;
            r_key    <= '0;
        end else if (w_wr && !w_busy) begin
            for (int i = 0; i < 4; i++) begin
                if (w_word == 6'(i))
                    r_cipher[127-32*i -: 32] <= f_merge(r_cipher[127-32*i -: 32], wbs_dat_i, wbs_sel_i);
                if (w_word == 6'(i + 4))
                    r_key[127-32*i -: 32] <= f_merge(r_key[127-32*i -: 32], wbs_dat_i, wbs_sel_i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge decReset_n) begin
        if (!decReset_n) r_state <= S_IDLE;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_core_rst   = 1'b1;
        w_busy       = 1'b0;
        w_irq        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_start) w_state_next = S_CRST;
            end
            S_CRST: begin
                w_busy       = 1'b1;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_core_rst = 1'b0;
                w_busy     = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_irq        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge decReset_n) begin
        if (!decReset_n) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            if (r_state == S_CRST)      r_cnt <= '0;
            else if (r_state == S_RUN)  r_cnt <= r_cnt + 1'b1;

            if (r_state == S_IDLE && r_start) begin
                r_done <= 1'b0;
            end else if (w_irq) begin
                r_done   <= 1'b1;
                r_result <= core_out;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign core_in   = r_cipher;
    assign core_key  = r_key;
    assign core_rst  = w_core_rst;
    assign irq       = w_irq;

endmodule
`default_nettype wire

// File: tb/tb_aes_wb_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_wb_loader
// Purpose  : Self-checking bench for aes_wb_loader. A stand-in for the
//            decrypt core returns a known function of key/ciphertext only
//            once DEC_LATENCY cycles have elapsed since its reset release
//            (and the complement before that), so early or late capture shows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_wb_loader;

    localparam int           L      = 12;
    localparam logic [31:0]  BASE   = 32'h3000_0000;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk        = 1'b0;
    logic         decReset_n = 1'b0;
    logic         wbs_cyc_i  = 1'b0;
    logic         wbs_stb_i  = 1'b0;
    logic         wbs_we_i   = 1'b0;
    logic [3:0]   wbs_sel_i  = 4'h0;
    logic [31:0]  wbs_adr_i  = 32'h0;
    logic [31:0]  wbs_dat_i  = 32'h0;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [127:0] core_in;
    logic [127:0] core_key;
    logic         core_rst;
    logic [127:0] core_out   = '0;
    logic         irq;

    aes_wb_loader #(.BASE_ADDR(BASE), .DEC_LATENCY(L)) u_dut (
        .clk        (clk),
        .decReset_n (decReset_n),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .core_in    (core_in),
        .core_key   (core_key),
        .core_rst   (core_rst),
        .core_out   (core_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] core_fn(input logic [127:0] c, input logic [127:0] k);
        if (c == C1_CT && k == C1_KEY) return C1_PT;
        return c ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_c3c3_a5a5_f0f0_1234_8765;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Core stand-in: counts cycles since core_rst released.
    int rel_cnt = 0;
    always @(negedge clk) begin
        if (core_rst) rel_cnt = 0;
        else          rel_cnt++;
        core_out = (rel_cnt >= L) ? core_fn(core_in, core_key) : ~core_fn(core_in, core_key);
    end

    // Event monitor, sampled 1 time unit after each rising edge.
    int cyc_n = 0, irq_cnt = 0, last_irq = -1, dbl_ack = 0, rst_low_cnt = 0;
    bit prev_ack = 1'b0;
    always @(posedge clk) begin
        cyc_n++;
        #1;
        if (irq === 1'b1) begin irq_cnt++; last_irq = cyc_n; end
        if (wbs_ack_o === 1'b1 && prev_ack) dbl_ack++;
        prev_ack = (wbs_ack_o === 1'b1);
        if (core_rst === 1'b0) rst_low_cnt++;
    end

    // Reference model of the register file.
    logic [31:0]  m_cipher [4];
    logic [31:0]  m_key    [4];
    logic [127:0] m_result;

    function automatic logic [127:0] m_ct();
        return {m_cipher[0], m_cipher[1], m_cipher[2], m_cipher[3]};
    endfunction
    function automatic logic [127:0] m_k();
        return {m_key[0], m_key[1], m_key[2], m_key[3]};
    endfunction

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdat,
                             output bit acked, output int ack_cyc);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        acked = 1'b0; rdat = '0; ack_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o === 1'b1) begin
                acked = 1'b1; rdat = wbs_dat_o; ack_cyc = cyc_n;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel,
                            output int ack_cyc);
        logic [31:0] rd; bit ak;
        wb_access(1'b1, BASE + off, dat, sel, rd, ak, ack_cyc);
        check($sformatf("wr_ack@%0h", off), 128'(ak), 128'(1));
    endtask

    task automatic wb_read(input logic [31:0] off, output logic [31:0] rd);
        bit ak; int ac;
        wb_access(1'b0, BASE + off, 32'h0, 4'hF, rd, ak, ac);
        check($sformatf("rd_ack@%0h", off), 128'(ak), 128'(1));
    endtask

    task automatic wait_to(input int t);
        while (cyc_n < t) begin @(posedge clk); #1; end
    endtask

    // Register write that also updates the model (caller says whether busy).
    task automatic reg_write(input int w, input logic [31:0] d, input logic [3:0] s, input bit busy);
        int ac;
        wb_write(32'(4 * w), d, s, ac);
        if (!busy) begin
            if (w < 4) m_cipher[w]  = lane_merge(m_cipher[w], d, s);
            else       m_key[w - 4] = lane_merge(m_key[w - 4], d, s);
        end
    endtask

    task automatic load_block(input logic [127:0] ct, input logic [127:0] k);
        for (int w = 0; w < 4; w++) begin
            reg_write(w,     ct[127-32*w -: 32], 4'hF, 1'b0);
            reg_write(w + 4, k[127-32*w -: 32],  4'hF, 1'b0);
        end
    endtask

    task automatic read_result(input string tag);
        logic [31:0] rd;
        for (int w = 0; w < 4; w++) begin
            wb_read(32'h24 + 32'(4 * w), rd);
            check($sformatf("%s_res%0d", tag, w), 128'(rd), 128'(m_result[127-32*w -: 32]));
        end
    endtask

    // Check a run started with ack on cycle c0: irq timing, run window, results.
    task automatic finish_run(input string tag, input int c0, input int irq0, input int rl0);
        logic [31:0] rd;
        wait_to(c0 + L + 3);
        check({tag, "_irq_cycle"}, 128'(last_irq), 128'(c0 + L + 1));
        check({tag, "_irq_count"}, 128'(irq_cnt - irq0), 128'(1));
        check({tag, "_run_cycles"}, 128'(rst_low_cnt - rl0), 128'(L));
        m_result = core_fn(m_ct(), m_k());
        wb_read(32'h20, rd);
        check({tag, "_ctrl"}, 128'(rd), 128'(2));
        read_result(tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        logic [3:0]  s;
        int c0, c1, irq0, rl0, ac, w;
        bit ak;

        for (int i = 0; i < 4; i++) begin m_cipher[i] = '0; m_key[i] = '0; end
        m_result = '0;

        // ---- reset values ----
        #12;
        check("rst_ack", 128'(wbs_ack_o), 128'(0));
        check("rst_dat", 128'(wbs_dat_o), 128'(0));
        check("rst_irq", 128'(irq), 128'(0));
        check("rst_core_rst", 128'(core_rst), 128'(1));
        check("rst_core_in", core_in, 128'(0));
        @(negedge clk); decReset_n = 1'b1;
        wb_read(32'h20, rd); check("rst_ctrl", 128'(rd), 128'(0));
        wb_read(32'h24, rd); check("rst_res0", 128'(rd), 128'(0));

        // ---- FIPS-197 C.1 vector ----
        load_block(C1_CT, C1_KEY);
        check("c1_core_in", core_in, C1_CT);
        check("c1_core_key", core_key, C1_KEY);
        irq0 = irq_cnt; rl0 = rst_low_cnt;
        wb_write(32'h20, 32'h1, 4'h1, c0);
        finish_run("c1", c0, irq0, rl0);
        check("c1_plain", m_result, C1_PT);

        // ---- back-to-back reads of RESULT ----
        ac = dbl_ack;
        read_result("b2b");
        check("b2b_no_double_ack", 128'(dbl_ack - ac), 128'(0));

        // ---- byte lanes, RO result, unmapped and undecoded addresses ----
        reg_write(0, 32'h0, 4'hF, 1'b0);
        reg_write(0, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        wb_read(32'h00, rd); check("lane_w0", 128'(rd), 128'(32'h0000_FF00));
        wb_write(32'h24, 32'h1234_5678, 4'hF, ac);
        wb_read(32'h24, rd); check("ro_res0", 128'(rd), 128'(m_result[127:96]));
        wb_read(32'h34, rd); check("unmapped_rd", 128'(rd), 128'(0));
        wb_access(1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, rd, ak, ac);
        check("nodecode_noack", 128'(ak), 128'(0));
        check("nodecode_core_in", core_in, m_ct());
        reg_write(0, C1_CT[127:96], 4'hF, 1'b0);

        // ---- writes and a second start while busy ----
        irq0 = irq_cnt; rl0 = rst_low_cnt;
        wb_write(32'h20, 32'h1, 4'h1, c0);
        wait_to(c0 + 2);
        reg_write(4, 32'hDEAD_BEEF, 4'hF, 1'b1);
        check("busy_key_held", core_key, C1_KEY);
        wb_write(32'h20, 32'h1, 4'h1, ac);
        finish_run("busy", c0, irq0, rl0);
        check("busy_plain", m_result, C1_PT);
        repeat (L + 4) @(posedge clk);
        #1 check("busy_single_irq", 128'(irq_cnt - irq0), 128'(1));

        // ---- start landing on the completion edge is ignored ----
        irq0 = irq_cnt; rl0 = rst_low_cnt;
        wb_write(32'h20, 32'h1, 4'h1, c1);
        wait_to(c1 + L + 1);
        wb_write(32'h20, 32'h1, 4'h1, ac);
        check("edge_start_cycle", 128'(ac), 128'(c1 + L + 2));
        finish_run("edge", c1, irq0, rl0);
        repeat (L + 4) @(posedge clk);
        #1 check("edge_no_rerun", 128'(irq_cnt - irq0), 128'(1));

        // ---- reset in the middle of RUN ----
        irq0 = irq_cnt;
        wb_write(32'h20, 32'h1, 4'h1, c0);
        wait_to(c0 + 2 + 5);
        decReset_n = 1'b0;
        #1;
        check("midrst_core_rst", 128'(core_rst), 128'(1));
        check("midrst_irq", 128'(irq), 128'(0));
        @(negedge clk); decReset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin m_cipher[i] = '0; m_key[i] = '0; end
        m_result = '0;
        repeat (L + 4) @(posedge clk);
        #1 check("midrst_no_irq", 128'(irq_cnt - irq0), 128'(0));
        wb_read(32'h20, rd); check("midrst_ctrl", 128'(rd), 128'(0));
        read_result("midrst");
        check("midrst_core_key", core_key, 128'(0));
        load_block(C1_CT, C1_KEY);
        irq0 = irq_cnt; rl0 = rst_low_cnt;
        wb_write(32'h20, 32'h1, 4'h1, c0);
        finish_run("after_rst", c0, irq0, rl0);

        // ---- randomized loads with partial byte lanes ----
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) reg_write(k, $urandom, 4'hF, 1'b0);
            for (int k = 0; k < 3; k++) begin
                w = $urandom_range(0, 7);
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                reg_write(w, d, s, 1'b0);
            end
            check($sformatf("rnd%0d_core_in", r), core_in, m_ct());
            check($sformatf("rnd%0d_core_key", r), core_key, m_k());
            w = $urandom_range(0, 7);
            wb_read(32'(4 * w), rd);
            check($sformatf("rnd%0d_readback", r), 128'(rd),
                  128'((w < 4) ? m_cipher[w] : m_key[w - 4]));
            irq0 = irq_cnt; rl0 = rst_low_cnt;
            wb_write(32'h20, 32'h1, 4'h1, c0);
            finish_run($sformatf("rnd%0d", r), c0, irq0, rl0);
        end

        check("final_no_double_ack", 128'(dbl_ack), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
